// File: rtl/arb_resp_router_pkg.sv
// Shared types and helpers for the arbiter response router.
package arb_resp_router_pkg;

  // Number of bits needed to hold a count in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Pointer width for a depth-entry ring; a single entry still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // FIFO entry for the default four-master configuration. The top level
  // derives the same shape from its own NumIn when it is overridden.
  localparam int unsigned DefNumIn    = 4;
  localparam int unsigned DefIdxWidth = $clog2(DefNumIn);
  typedef logic [DefIdxWidth-1:0] fifo_entry_t;

endpackage

// File: rtl/idx_fifo.sv
// In-order FIFO of winning master indices. Depth need not be a power of two:
// pointers wrap explicitly at Depth-1. Flush has priority over push and pop.
module idx_fifo
  import arb_resp_router_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned Width = 2,
  localparam int unsigned CntW  = cnt_width(Depth),
  localparam int unsigned PtrW  = ptr_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; count moves only on a lone push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; writes are dropped in a flush cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/arb_resp_router.sv
// Forwards the arbitrated request to the single slave and routes in-order
// responses back to the master recorded at the FIFO head.
// Optional: define ARB_RESP_ROUTER_ERR_EN to consume orphan responses
// (arriving with nothing outstanding) and flag them on a sticky err_o.
module arb_resp_router
  import arb_resp_router_pkg::*;
#(
  parameter  int unsigned NumIn    = 4,
  parameter  int unsigned ReqWidth = 64,
  parameter  int unsigned RspWidth = 33,
  parameter  int unsigned MaxTrans = 4,
  localparam int unsigned IdxWidth = $clog2(NumIn),
  localparam int unsigned CntW     = cnt_width(MaxTrans)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  // arbiter side
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ReqWidth-1:0] req_data_i,
  input  logic [IdxWidth-1:0] idx_i,
  // slave side
  output logic                req_o,
  input  logic                gnt_i,
  output logic [ReqWidth-1:0] req_data_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  logic [RspWidth-1:0] rsp_data_i,
  // per-master response
  output logic [NumIn-1:0]    mst_rsp_valid_o,
  input  logic [NumIn-1:0]    mst_rsp_ready_i,
  output logic [RspWidth-1:0] mst_rsp_data_o,
`ifdef ARB_RESP_ROUTER_ERR_EN
  output logic                err_o,
`endif
  output logic [CntW-1:0]     outstanding_o
);

  typedef logic [IdxWidth-1:0] entry_t;

  entry_t head;
  logic   full, empty;
  logic   push, pop;
  logic   head_rdy;

  idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxWidth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (idx_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  // Request path is pure wiring; full stalls both sides so the arbiter holds.
  assign req_o      = req_i & ~full;
  assign gnt_o      = gnt_i & ~full & ~flush_i;
  assign req_data_o = req_data_i;
  assign push       = req_o & gnt_i & ~flush_i;

  // Decode the head index into per-master valids and pick that master's ready.
  always_comb begin
    mst_rsp_valid_o = '0;
    head_rdy        = 1'b0;
    for (int k = 0; k < int'(NumIn); k++) begin
      if (head == entry_t'(k)) begin
        mst_rsp_valid_o[k] = rsp_valid_i & ~empty;
        head_rdy           = mst_rsp_ready_i[k];
      end
    end
  end

  assign mst_rsp_data_o = rsp_data_i;
  assign pop            = rsp_valid_i & rsp_ready_o & ~empty;

`ifdef ARB_RESP_ROUTER_ERR_EN
  logic err_q, err_d;
  logic orphan;

  // Orphans are swallowed so the slave never deadlocks on a stray response.
  assign rsp_ready_o = ~flush_i & (empty | head_rdy);
  assign orphan      = rsp_valid_i & empty & ~flush_i;
  assign err_o       = err_q;

  // Sticky error: set by an orphan, cleared only by flush.
  always_comb begin
    err_d = err_q | orphan;
    if (flush_i) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  // Orphans stall here; nothing should ever send one.
  assign rsp_ready_o = ~flush_i & ~empty & head_rdy;

`ifndef SYNTHESIS
  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_valid_i && empty))
    else $error("arb_resp_router: response with no outstanding transaction");
`endif
`endif

endmodule

// File: doc/arb_resp_router.md
Name: arb_resp_router

Overview:
- Sits directly downstream of the round-robin arbitration tree in the AXI-to-Wishbone interconnect.
- Forwards the arbitrated request (req/data/idx) to the single downstream slave port.
- Records the winning master index in an in-order FIFO for each accepted request.
- Routes each returning response to the master at the FIFO head. Multiple transactions may be outstanding, and responses return in order.

Parameters:
- NumIn, 4, number of upstream masters; must be ≥2.
- ReqWidth, 64, request payload width.
- RspWidth, 33, response payload width.
- MaxTrans, 4, maximum outstanding transactions (FIFO depth); ≥1, need not be a power of two.
- IdxWidth, derived = $clog2(NumIn), do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous clear of the outstanding-index FIFO.
- req_i  in  1  arbitrated request valid (from arbiter req_o).
- gnt_o  out  1  grant back to the arbiter (to arbiter gnt_i).
- req_data_i  in  ReqWidth  arbitrated payload.
- idx_i  in  IdxWidth  index of the winning master.
- req_o  out  1  request to the slave.
- gnt_i  in  1  slave accepts the request.
- req_data_o  out  ReqWidth  payload to the slave.
- rsp_valid_i  in  1  slave response valid.
- rsp_ready_o  out  1  response accepted.
- rsp_data_i  in  RspWidth  response payload.
- mst_rsp_valid_o  out  NumIn  per-master response valid.
- mst_rsp_ready_i  in  NumIn  per-master response ready.
- mst_rsp_data_o  out  RspWidth  response payload, broadcast to all masters.
- outstanding_o  out  $clog2(MaxTrans+1)  current FIFO occupancy.

Behaviour:

Reset and flush:
- On reset: FIFO empty, wr_ptr=rd_ptr=count=0, outstanding_o=0.
- All outputs are combinational from state and inputs. Under reset with idle inputs they are 0.

Request path (zero latency, no register):
- req_o = req_i & ~full.
- gnt_o = gnt_i & ~full.
- req_data_o = req_data_i.
- Push idx_i when req_o & gnt_i.

Full condition:
- full = (count == MaxTrans).
- While full, req_o=0 and gnt_o=0, so the arbiter holds its decision.

Response path:
- head = fifo[rd_ptr].
- mst_rsp_valid_o[k] = rsp_valid_i & ~empty & (head==k).
- rsp_ready_o = mst_rsp_ready_i[head] & ~empty.
- mst_rsp_data_o = rsp_data_i.
- Pop when rsp_valid_i & rsp_ready_o.

Pointers and count:
- Pointers wrap from MaxTrans-1 to 0.
- count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.

Boundary cases:
- Full with a simultaneous pop: push is still blocked that cycle. There is no fall-through, which keeps gnt_o independent of the response path.
- Empty with a simultaneous push: the response is not bypassed. A response needs at least one cycle after its request handshake.

flush_i:
- Next cycle: pointers and count go to 0.
- Same cycle: gnt_o and rsp_ready_o are forced to 0, so no handshake completes in the flush cycle.
- Outstanding responses are discarded by design.

Optional Feature:
- Macro: ARB_RESP_ROUTER_ERR_EN.
- Defined: adds output err_o (1 bit, sticky, reset 0, cleared by flush_i).
  - A response arriving while empty is consumed (rsp_ready_o=1), not routed to any master, and sets err_o.
  - err_o asserts the cycle after the orphan response.
- Undefined:
  - No err_o port.
  - rsp_ready_o=0 while empty, so orphan responses stall.
  - A simulation-only assertion flags rsp_valid_i while empty.

Decomposition:
- Package arb_resp_router_pkg holds:
  - the count-width helper function;
  - a typedef for the FIFO entry (logic [IdxWidth-1:0]).
- Sub-module idx_fifo contains the FIFO storage, pointers, count and full/empty logic.
  - Parameters: Depth, Width.
  - Interface: push, pop, flush, data_in, data_out, full, empty, count.
- The top level keeps only the routing and gating logic.

Test Plan:
1. Single transaction, NumIn=4:
   - Stimulus: req_i=1, idx_i=2, gnt_i=1 for one cycle; two cycles later rsp_valid_i=1, mst_rsp_ready_i=4'b0100.
   - Expect: gnt_o=1, outstanding_o=1; then mst_rsp_valid_o=4'b0100, rsp_ready_o=1, outstanding_o returns to 0.
2. Fill to MaxTrans=4:
   - Stimulus: push idx 0,1,3,2 on consecutive cycles, then a fifth request.
   - Expect: req_o=0 and gnt_o=0 for the fifth request.
   - Then return 4 responses and expect routing in order 0,1,3,2.
3. Full with simultaneous pop:
   - Stimulus: count=4, req_i=1 and a response handshake in the same cycle.
   - Expect: gnt_o=0; count becomes 3; the request is granted in the next cycle.
4. Head master not ready:
   - Stimulus: head=1, mst_rsp_ready_i=4'b1101.
   - Expect: rsp_ready_o=0 and no pop until bit 1 rises.
5. Flush mid-operation:
   - Stimulus: count=3, flush_i=1 with rsp_valid_i=1.
   - Expect: rsp_ready_o=0 and gnt_o=0 that cycle; outstanding_o=0 the next cycle.
6. Orphan response:
   - Stimulus: empty FIFO, rsp_valid_i=1.
   - With ARB_RESP_ROUTER_ERR_EN: rsp_ready_o=1, mst_rsp_valid_o=0, err_o=1 next cycle.
   - Without it: rsp_ready_o=0 and the assertion fires.
